// File: rtl/sweep_stim_checker_pkg.sv
// Shared types and helpers for the exhaustive truth-table sweep checker.
package sweep_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_e;

    // Smallest legal hold time per pattern.
    localparam int HOLD_MIN = 1;

    // Bits needed to hold values 0..v-1; never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < v) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sweep_stim_checker_hold_timer.sv
// Per-pattern hold timer: counts HOLD-1 down to 0 and reloads.
// last_o marks the final cycle of the hold window.
module sweep_hold_timer
    import sweep_pkg::*;
#(
    parameter int HOLD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic last_o
);

    localparam int CW = clog2(HOLD);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear beats load beats count; reload after the last cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_ZERO;
        end else if (load_i) begin
            cnt_d = CNT_RELOAD;
        end else if (en_i) begin
            if (cnt_q == CNT_ZERO) begin
                cnt_d = CNT_RELOAD;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/sweep_stim_checker.sv
// Exhaustive stimulus sweep with truth-table response checking.
// Drives patterns 0..2**N_IN-1, holds each HOLD cycles, samples resp on the
// last hold cycle and latches pass / mismatch count / first failing index.
module sweep_stim_checker
    import sweep_pkg::*;
#(
    parameter int                     N_IN   = 3,
    parameter int                     HOLD   = 10,
    parameter logic [(1<<N_IN)-1:0]   EXPECT = 8'h96
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            loop_en,
    input  logic            resp,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            sweep_end,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_err_idx,
    output logic            err_valid
);

    if (HOLD < HOLD_MIN) begin : g_bad_hold
        $error("sweep_stim_checker: HOLD must be at least HOLD_MIN");
    end
    if ((N_IN < 1) || (N_IN > 8)) begin : g_bad_nin
        $error("sweep_stim_checker: N_IN must be in 1..8");
    end

    localparam logic [N_IN-1:0] IDX_ZERO = {N_IN{1'b0}};
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
    localparam logic [N_IN:0]   ERR_ZERO = {(N_IN+1){1'b0}};

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN:0]   run_err_q, run_err_d;
    logic [N_IN-1:0] run_first_q, run_first_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_cnt_q, err_cnt_d;
    logic [N_IN-1:0] first_err_q, first_err_d;
    logic            err_valid_q, err_valid_d;
    logic            sweep_end_q, sweep_end_d;

    logic            tmr_clr_s, tmr_load_s, tmr_en_s, tmr_last_s;
    logic            mism_s;
    logic [N_IN:0]   err_next_s;
    logic [N_IN-1:0] first_next_s;

    sweep_hold_timer #(.HOLD(HOLD)) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tmr_clr_s),
        .load_i (tmr_load_s),
        .en_i   (tmr_en_s),
        .last_o (tmr_last_s)
    );

    // Running counters as they stand after the compare of the current pattern.
    always_comb begin
        mism_s     = (resp != EXPECT[idx_q]);
        err_next_s = run_err_q + {{N_IN{1'b0}}, mism_s};
        if (mism_s && (run_err_q == ERR_ZERO)) begin
            first_next_s = idx_q;
        end else begin
            first_next_s = run_first_q;
        end
    end

    // Sweep FSM: next state, pattern index, running counters and result latches.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        run_err_d   = run_err_q;
        run_first_d = run_first_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_valid_d = err_valid_q;
        sweep_end_d = 1'b0;
        tmr_clr_s   = 1'b0;
        tmr_load_s  = 1'b0;
        tmr_en_s    = 1'b0;
        if (abort) begin
            state_d   = ST_IDLE;
            idx_d     = IDX_ZERO;
            tmr_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d     = ST_RUN;
                        idx_d       = IDX_ZERO;
                        run_err_d   = ERR_ZERO;
                        run_first_d = IDX_ZERO;
                        tmr_load_s  = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    tmr_en_s = 1'b1;
                    if (tmr_last_s) begin
                        if (idx_q != IDX_LAST) begin
                            idx_d       = idx_q + IDX_ONE;
                            run_err_d   = err_next_s;
                            run_first_d = first_next_s;
                        end else begin
                            // Final pattern: latch results including this compare.
                            pass_d      = (err_next_s == ERR_ZERO);
                            err_cnt_d   = err_next_s;
                            err_valid_d = (err_next_s != ERR_ZERO);
                            first_err_d = (err_next_s != ERR_ZERO) ? first_next_s : IDX_ZERO;
                            sweep_end_d = 1'b1;
                            run_err_d   = ERR_ZERO;
                            run_first_d = IDX_ZERO;
                            if (loop_en) begin
                                idx_d = IDX_ZERO;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        idx_d = idx_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = IDX_ZERO;
                end
            endcase
        end
    end

    // State, counters and latched results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= IDX_ZERO;
            run_err_q   <= ERR_ZERO;
            run_first_q <= IDX_ZERO;
            pass_q      <= 1'b0;
            err_cnt_q   <= ERR_ZERO;
            first_err_q <= IDX_ZERO;
            err_valid_q <= 1'b0;
            sweep_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            run_err_q   <= run_err_d;
            run_first_q <= run_first_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_valid_q <= err_valid_d;
            sweep_end_q <= sweep_end_d;
        end
    end

    assign stim          = idx_q;
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign sweep_end     = sweep_end_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;
    assign err_valid     = err_valid_q;

endmodule

// File: tb/tb_sweep_stim_checker.sv
// Bench for sweep_stim_checker: two instances (HOLD=2 and HOLD=1), a
// sweep-level reference model, per-cycle comparison and directed scenarios.
module tb_sweep_stim_checker;

    localparam logic [7:0] EXP_TT = 8'h96;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // HOLD=2 instance signals
    logic       start2 = 1'b0, abort2 = 1'b0, loop2 = 1'b0;
    logic [7:0] fault2 = 8'h00;
    logic       resp2, busy2, se2, done2, pass2, ev2;
    logic [2:0] stim2, fidx2;
    logic [3:0] errc2;
    // HOLD=1 instance signals
    logic       start1 = 1'b0, abort1 = 1'b0, loop1 = 1'b0;
    logic [7:0] fault1 = 8'h00;
    logic       resp1, busy1, se1, done1, pass1, ev1;
    logic [2:0] stim1, fidx1;
    logic [3:0] errc1;

    // Emulated combinational DUT: 3-input XOR with per-pattern fault injection.
    assign resp2 = (^stim2) ^ fault2[stim2];
    assign resp1 = (^stim1) ^ fault1[stim1];

    sweep_stim_checker #(.N_IN(3), .HOLD(2), .EXPECT(8'h96)) dut_h2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .loop_en(loop2),
        .resp(resp2), .stim(stim2), .busy(busy2), .sweep_end(se2), .done(done2),
        .pass(pass2), .err_cnt(errc2), .first_err_idx(fidx2), .err_valid(ev2));

    sweep_stim_checker #(.N_IN(3), .HOLD(1), .EXPECT(8'h96)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .loop_en(loop1),
        .resp(resp1), .stim(stim1), .busy(busy1), .sweep_end(se1), .done(done1),
        .pass(pass1), .err_cnt(errc1), .first_err_idx(fidx1), .err_valid(ev1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 done; t = cycles into sweep.
    typedef struct {
        int mode; int t; int errs; int first; int stim;
        bit se; bit pass; int err_cnt; int fidx; bit ev;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t n;
        n.mode = 0; n.t = 0; n.errs = 0; n.first = 0; n.stim = 0;
        n.se = 1'b0; n.pass = 1'b0; n.err_cnt = 0; n.fidx = 0; n.ev = 1'b0;
        return n;
    endfunction

    function automatic bit dut_f(input int p, input logic [7:0] flt);
        logic [2:0] pv;
        pv = p[2:0];
        return (^pv) ^ flt[pv];
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int hold, input bit st,
                                   input bit ab, input bit lp, input logic [7:0] flt);
        mdl_t n;
        int   p;
        n = m;
        n.se = 1'b0;
        if (ab) begin
            n.mode = 0; n.stim = 0;
            return n;
        end
        if (n.mode != 1) begin
            if (st) begin
                n.mode = 1; n.t = 0; n.errs = 0; n.first = 0; n.stim = 0;
            end
            return n;
        end
        p = n.t / hold;
        if ((n.t % hold) == hold - 1 && dut_f(p, flt) != EXP_TT[p]) begin
            if (n.errs == 0) n.first = p;
            n.errs++;
        end
        n.t++;
        if (n.t == 8 * hold) begin
            n.pass = (n.errs == 0); n.err_cnt = n.errs; n.ev = (n.errs != 0);
            n.fidx = (n.errs != 0) ? n.first : 0;
            n.se = 1'b1; n.t = 0; n.errs = 0; n.first = 0;
            if (lp) n.stim = 0;
            else begin n.mode = 2; n.stim = 7; end
        end else begin
            n.stim = n.t / hold;
        end
        return n;
    endfunction

    mdl_t m2, m1;

    // Advance both models on each clock; async reset mirrors rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2 <= mreset();
            m1 <= mreset();
        end else begin
            m2 <= mstep(m2, 2, start2, abort2, loop2, fault2);
            m1 <= mstep(m1, 1, start1, abort1, loop1, fault1);
        end
    end

    task automatic cmp_inst(input string tg, input mdl_t m, input logic [2:0] st,
                            input logic bz, input logic se, input logic dn, input logic ps,
                            input logic [3:0] ec, input logic [2:0] fi, input logic ev);
        chk({tg, ".stim"}, st, m.stim);
        chk({tg, ".busy"}, bz, m.mode == 1);
        chk({tg, ".done"}, dn, m.mode == 2);
        chk({tg, ".sweep_end"}, se, m.se);
        chk({tg, ".pass"}, ps, m.pass);
        chk({tg, ".err_cnt"}, ec, m.err_cnt);
        chk({tg, ".first_err_idx"}, fi, m.fidx);
        chk({tg, ".err_valid"}, ev, m.ev);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            cmp_inst("h2", m2, stim2, busy2, se2, done2, pass2, errc2, fidx2, ev2);
            cmp_inst("h1", m1, stim1, busy1, se1, done1, pass1, errc1, fidx1, ev1);
        end
    end

    task automatic pulse_start(input bit h1);
        if (h1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
    endtask

    // Cycles until sweep_end is seen, bounded.
    task automatic wait_se(input bit h1, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(h1 ? se1 : se2) && cnt < 200);
    endtask

    task automatic wait_stim(input bit h1, input logic [2:0] v);
        int n;
        n = 0;
        while ((h1 ? stim1 : stim2) != v && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_stim", h1 ? stim1 : stim2, v);
    endtask

    task automatic chk_reset_vals(input string tg, input logic [2:0] st, input logic bz,
                                  input logic se, input logic dn, input logic ps,
                                  input logic [3:0] ec, input logic [2:0] fi, input logic ev);
        chk({tg, ".rst_stim"}, st, 3'd0);
        chk({tg, ".rst_busy"}, bz, 1'b0);
        chk({tg, ".rst_se"}, se, 1'b0);
        chk({tg, ".rst_done"}, dn, 1'b0);
        chk({tg, ".rst_pass"}, ps, 1'b0);
        chk({tg, ".rst_errc"}, ec, 4'd0);
        chk({tg, ".rst_fidx"}, fi, 3'd0);
        chk({tg, ".rst_ev"}, ev, 1'b0);
    endtask

    int cnt;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("h2", stim2, busy2, se2, done2, pass2, errc2, fidx2, ev2);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean sweep, HOLD=2: 16 cycles, pass.
        pulse_start(1'b0);
        wait_se(1'b0, cnt);
        chk("s1_len", cnt, 16);
        chk("s1_pass", pass2, 1'b1);
        chk("s1_errc", errc2, 4'd0);
        chk("s1_ev", ev2, 1'b0);
        @(negedge clk);
        chk("s1_done", done2, 1'b1);
        chk("s1_stim_hold", stim2, 3'd7);

        // Single fault at pattern 5.
        fault2 = 8'h20;
        pulse_start(1'b0);
        wait_se(1'b0, cnt);
        chk("s2_errc", errc2, 4'd1);
        chk("s2_fidx", fidx2, 3'd5);
        chk("s2_ev", ev2, 1'b1);
        chk("s2_pass", pass2, 1'b0);

        // Inverted response: every pattern fails.
        fault2 = 8'hFF;
        pulse_start(1'b0);
        wait_se(1'b0, cnt);
        chk("s3_errc", errc2, 4'b1000);
        chk("s3_fidx", fidx2, 3'd0);
        chk("s3_pass", pass2, 1'b0);

        // Continuous loop: three sweeps, fault only in the second.
        fault2 = 8'h00;
        loop2 = 1'b1;
        pulse_start(1'b0);
        wait_se(1'b0, cnt);
        chk("s4a_len", cnt, 16);
        chk("s4a_pass", pass2, 1'b1);
        fault2 = 8'h08;
        wait_se(1'b0, cnt);
        chk("s4b_len", cnt, 16);
        chk("s4b_busy", busy2, 1'b1);
        chk("s4b_pass", pass2, 1'b0);
        chk("s4b_errc", errc2, 4'd1);
        chk("s4b_fidx", fidx2, 3'd3);
        fault2 = 8'h00;
        loop2 = 1'b0;
        wait_se(1'b0, cnt);
        chk("s4c_len", cnt, 16);
        chk("s4c_pass", pass2, 1'b1);
        @(negedge clk);
        chk("s4c_done", done2, 1'b1);

        // HOLD=1: 8-cycle sweep, then abort and start+abort.
        pulse_start(1'b1);
        wait_se(1'b1, cnt);
        chk("s5_len", cnt, 8);
        chk("s5_pass", pass1, 1'b1);
        pulse_start(1'b1);
        wait_stim(1'b1, 3'd4);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("s5_abort_busy", busy1, 1'b0);
        chk("s5_abort_stim", stim1, 3'd0);
        chk("s5_abort_se", se1, 1'b0);
        chk("s5_abort_pass", pass1, 1'b1);
        start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; abort1 = 1'b0;
        chk("s5_startabort_busy", busy1, 1'b0);

        // Randomized traffic on both instances, checked by the model.
        for (int i = 0; i < 800; i++) begin
            start2 = ($urandom_range(0, 5) == 0);
            abort2 = ($urandom_range(0, 59) == 0);
            start1 = ($urandom_range(0, 5) == 0);
            abort1 = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 31) == 0) loop2 = $urandom_range(0, 1);
            if ($urandom_range(0, 31) == 0) loop1 = $urandom_range(0, 1);
            if ($urandom_range(0, 23) == 0)
                fault2 = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 23) == 0)
                fault1 = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        start2 = 1'b0; start1 = 1'b0; loop2 = 1'b0; loop1 = 1'b0;
        fault2 = 8'h00; fault1 = 8'h00;
        abort2 = 1'b1; abort1 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0; abort1 = 1'b0;

        // Async reset mid-sweep, then a clean sweep.
        pulse_start(1'b0);
        wait_stim(1'b0, 3'd6);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("h2", stim2, busy2, se2, done2, pass2, errc2, fidx2, ev2);
        chk_reset_vals("h1", stim1, busy1, se1, done1, pass1, errc1, fidx1, ev1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(1'b0);
        wait_se(1'b0, cnt);
        chk("s6_len", cnt, 16);
        chk("s6_pass", pass2, 1'b1);
        chk("s6_ev", ev2, 1'b0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sweep_stim_checker.md
Name: sweep_stim_checker

Overview:
- Parametrised successor of our hand-written exhaustive truth-table fixtures.
- Drives every input combination of an N_IN-input combinational DUT in ascending binary order and holds each pattern for HOLD cycles.
- Samples the DUT's 1-bit response at the end of each hold window and compares it against an expected truth table.
- Reports a pass/fail result, a mismatch count and the index of the first failing pattern; supports single-shot and continuous-loop sweeps, plus abort.

Parameters:
- N_IN, 3, DUT input count; legal range 1..8.
- HOLD, 10, cycles each pattern is held; must be ≥1.
- EXPECT, 8'h96, expected truth table, width 2**N_IN; bit i is the expected f for stim==i (default is 3-input XOR).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; ignored while busy.
- abort  in  1  synchronous; stop the sweep and return to IDLE.
- loop_en  in  1  sampled at each sweep end; 1 = restart immediately.
- resp  in  1  DUT output f.
- stim  out  N_IN  pattern driven to the DUT.
- busy  out  1  high in RUN.
- sweep_end  out  1  one-cycle pulse when a sweep completes.
- done  out  1  high in DONE.
- pass  out  1  latched result of the last completed sweep.
- err_cnt  out  N_IN+1  latched mismatch count of the last completed sweep.
- first_err_idx  out  N_IN  latched index of the first mismatch.
- err_valid  out  1  latched; 1 if first_err_idx is meaningful.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; stim=0; busy=0; done=0; sweep_end=0; pass=0; err_cnt=0; first_err_idx=0; err_valid=0; all internal counters=0.
- State machine:
  - IDLE: start=1 → RUN, with idx=0, hold=0 and running counters cleared.
  - RUN: stim=idx. hold counts 0..HOLD-1.
    - At the edge where hold==HOLD-1: compare resp with EXPECT[idx]. On mismatch, increment run_err; if this is the first mismatch, record run_first=idx.
    - If idx<2**N_IN-1: idx+1, hold=0.
    - Otherwise the sweep ends: latch pass/err_cnt/first_err_idx/err_valid from the run counters including this final compare; sweep_end=1 for the next cycle. Then, if loop_en=1, stay in RUN with idx=0 and run counters cleared (no idle cycle); else → DONE.
  - DONE: done=1; stim holds the last pattern. start=1 → RUN (restart, as in IDLE).
- Abort: abort=1 in any state → IDLE next cycle; stim=0; latched results unchanged; no sweep_end. abort has priority over start and over a coincident sweep end.
- Timing:
  - Pattern i is driven for exactly HOLD cycles.
  - resp is sampled on the last of those cycles, giving the DUT HOLD-1 full cycles to settle.
  - Total sweep = 2**N_IN × HOLD cycles from the cycle after start.
  - HOLD=1 samples in the same cycle the pattern is applied, i.e. a combinational DUT path is required.
- Width rules:
  - err_cnt is N_IN+1 bits so that 2**N_IN fits; it never saturates or wraps.
  - idx wraps only via the sweep-end logic, never by overflow.
- pass = (err_cnt==0).
- err_valid = (err_cnt!=0); first_err_idx=0 when err_valid=0.
- start asserted during RUN has no effect; start and abort together → abort.
- Reset mid-sweep discards the partial sweep; no result is latched.

Decomposition:
- Shared package sweep_pkg:
  - state enum IDLE/RUN/DONE, 2-bit encoding;
  - clog2 function for the hold counter width;
  - HOLD_MIN=1 constant with an elaboration-time check.
- One sub-module, sweep_hold_timer: parametrised HOLD down-counter with load and last-cycle outputs, same clk/rst_n.
- FSM, compare logic and result latches stay in the top module.

Test Plan:
- N_IN=3, HOLD=2, EXPECT=8'h96, bench models f=a^b^c; start pulse → stim steps 0..7, each held 2 cycles; sweep_end at cycle 16 after start; pass=1, err_cnt=0, err_valid=0; done=1.
- Same setup, model forced wrong only at stim=5 → err_cnt=1, first_err_idx=5, err_valid=1, pass=0.
- Model output inverted (f=~(a^b^c)) → err_cnt=8 (4'b1000, no wrap), first_err_idx=0, pass=0.
- loop_en=1 for 3 sweeps, fault only in sweep 2 at stim=3 → three sweep_end pulses 16 cycles apart, never idle; latched results after each sweep are pass=1, then 0 (err_cnt=1, idx=3), then 1; clear loop_en → DONE.
- HOLD=1: full sweep completes in 8 cycles with pass=1. Abort asserted at idx=4 → IDLE, stim=0, previous results retained, no sweep_end. start together with abort → stays IDLE.
- rst_n low during RUN at idx=6 → all outputs return to reset values at once (async); a new start gives a clean full sweep with pass=1.
